flash_mem: RTL and testbench

FLASH_MEM -- requirements
Module: flash_mem

---
 rtl/flash_mem_pkg.sv | 14 +
 rtl/flash_mem_array.sv | 35 +++
 rtl/flash_mem.sv | 161 ++++++++++++++++
 tb/tb_flash_mem.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flash_mem_pkg.sv
// flash_mem_pkg: definitions shared by the flash_mem block.
//   flash_state_e            - access FSM encoding, also driven on flash_mem.state_dbg
//   FLASH_BASE_ADDR_DEFAULT  - default byte address of word 0
package flash_mem_pkg;

  localparam logic [31:0] FLASH_BASE_ADDR_DEFAULT = 32'h0800_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } flash_state_e;

endpackage

// File: rtl/flash_mem_array.sv
// flash_mem_array: single-port DEPTH_WORDS x 32 storage with per-byte write
// enables. Writes are synchronous; the read port is combinational so the
// controller can capture the word on the same edge that commits a write.
//   clock  - write clock
//   we     - write strobe
//   be     - byte lane enables, bit i covers wdata[8i+7:8i]
//   addr   - word index
//   wdata  - write data
//   rdata  - word currently stored at addr
module flash_mem_array #(
  parameter int DEPTH_WORDS = 256,
  localparam int IDX_W = $clog2(DEPTH_WORDS)
) (
  input  logic             clock,
  input  logic             we,
  input  logic [3:0]       be,
  input  logic [IDX_W-1:0] addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  // Contents start at zero and are never touched by reset.
  logic [31:0] mem [DEPTH_WORDS] = '{default: '0};

  always_ff @(posedge clock) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/flash_mem.sv
// flash_mem: word-addressed memory behind a request/response handshake with
// a configurable number of wait states per valid access.
//
// Handshake: a channel transfers on a rising clock edge where its valid and
// ready are both 1. req_ready is 1 only in IDLE, so one access is in flight
// at a time. A response is held (rsp_valid, rsp_rdata, rsp_error stable)
// until rsp_ready is seen; the response fields read as 0 outside RESP.
//
// Ports:
//   clock, reset          - rising-edge clock, asynchronous active-high reset
//   req_valid/req_ready   - request handshake
//   req_write             - 1 write, 0 read
//   req_addr              - byte address (word aligned, inside the window)
//   req_wdata, req_be     - write data and byte lane enables
//   rsp_valid/rsp_ready   - response handshake
//   rsp_rdata             - read data, 0 for writes and errors
//   rsp_error             - access rejected (range, alignment, read-only)
//   state_dbg             - current FSM state
module flash_mem
  import flash_mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = FLASH_BASE_ADDR_DEFAULT,
  parameter int          DEPTH_WORDS = 256,
  parameter int          WAIT_STATES = 2,
  parameter int          WRITABLE    = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_write,
  input  logic [31:0]  req_addr,
  input  logic [31:0]  req_wdata,
  input  logic [3:0]   req_be,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [31:0]  rsp_rdata,
  output logic         rsp_error,
  output flash_state_e state_dbg
);

  localparam int         IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAST_WAIT = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  flash_state_e state_q, state_d;
  logic [3:0]   wait_cnt_q, wait_cnt_d;
  logic         write_q;
  logic [31:0]  addr_q, wdata_q;
  logic [3:0]   be_q;
  logic [31:0]  rdata_q;
  logic         error_q;

  logic         accept;
  logic         load_rsp;
  logic         commit;
  logic         cur_write;
  logic [31:0]  cur_addr, cur_wdata;
  logic [3:0]   cur_be;
  logic [32:0]  offset;
  logic         req_err;
  logic [31:0]  array_rdata;

  assign accept = req_valid && (state_q == ST_IDLE);

  // In IDLE the access is decoded straight from the ports so a zero-wait
  // access can complete on its accept edge; afterwards the captured copy
  // is used and the ports are ignored.
  assign cur_write = (state_q == ST_IDLE) ? req_write : write_q;
  assign cur_addr  = (state_q == ST_IDLE) ? req_addr  : addr_q;
  assign cur_wdata = (state_q == ST_IDLE) ? req_wdata : wdata_q;
  assign cur_be    = (state_q == ST_IDLE) ? req_be    : be_q;

  // 33-bit offset: a borrow lands in bit 32, so "below base" and "past the
  // end" both show up as a non-zero bit above the word-index field, and
  // the upper bound can never wrap. BASE_ADDR is expected word aligned.
  assign offset  = {1'b0, cur_addr} - {1'b0, BASE_ADDR};
  assign req_err = (offset[32:IDX_W+2] != '0)
                || (cur_addr[1:0] != 2'b00) || (offset[1:0] != 2'b00)
                || (cur_write && (WRITABLE == 0));

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    load_rsp   = 1'b0;
    commit     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (req_err || (WAIT_STATES == 0)) begin
            state_d  = ST_RESP;
            load_rsp = 1'b1;
            commit   = cur_write && !req_err;
          end else begin
            state_d    = ST_WAIT;
            wait_cnt_d = 4'd0;
          end
        end
      end
      ST_WAIT: begin
        if (wait_cnt_q == LAST_WAIT) begin
          state_d    = ST_RESP;
          wait_cnt_d = 4'd0;
          load_rsp   = 1'b1;
          commit     = cur_write;
        end else begin
          wait_cnt_d = wait_cnt_q + 4'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= 4'd0;
      write_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      rdata_q    <= '0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      if (accept) begin
        write_q <= req_write;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        be_q    <= req_be;
      end
      // The word is read before the same edge's write lands, which is the
      // contents at the transition into RESP.
      if (load_rsp) begin
        rdata_q <= (req_err || cur_write) ? 32'h0 : array_rdata;
        error_q <= req_err;
      end
    end
  end

  flash_mem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clock(clock),
    .we   (commit),
    .be   (cur_be),
    .addr (offset[IDX_W+1:2]),
    .wdata(cur_wdata),
    .rdata(array_rdata)
  );

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rsp_valid ? rdata_q : 32'h0;
  assign rsp_error = rsp_valid && error_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_flash_mem.sv
module tb_flash_mem;
  import flash_mem_pkg::*;

  localparam logic [31:0] BASE = 32'h0800_0000;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic [7:0]  lat;
  } exp_t;

  exp_t exp_q0[$];
  exp_t exp_q1[$];

  // dut0: 2 wait states, writable. dut1: 0 wait states, read-only.
  logic         reset0, req_valid0, req_ready0, req_write0, rsp_valid0, rsp_ready0, rsp_error0;
  logic [31:0]  req_addr0, req_wdata0, rsp_rdata0;
  logic [3:0]   req_be0;
  flash_state_e state_dbg0;
  logic         reset1, req_valid1, req_ready1, req_write1, rsp_valid1, rsp_ready1, rsp_error1;
  logic [31:0]  req_addr1, req_wdata1, rsp_rdata1;
  logic [3:0]   req_be1;
  flash_state_e state_dbg1;

  flash_mem #(.BASE_ADDR(BASE), .DEPTH_WORDS(256), .WAIT_STATES(2), .WRITABLE(1)) dut0 (
    .clock(clock), .reset(reset0),
    .req_valid(req_valid0), .req_ready(req_ready0), .req_write(req_write0),
    .req_addr(req_addr0), .req_wdata(req_wdata0), .req_be(req_be0),
    .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0), .rsp_rdata(rsp_rdata0),
    .rsp_error(rsp_error0), .state_dbg(state_dbg0)
  );

  flash_mem #(.BASE_ADDR(BASE), .DEPTH_WORDS(256), .WAIT_STATES(0), .WRITABLE(0)) dut1 (
    .clock(clock), .reset(reset1),
    .req_valid(req_valid1), .req_ready(req_ready1), .req_write(req_write1),
    .req_addr(req_addr1), .req_wdata(req_wdata1), .req_be(req_be1),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_rdata(rsp_rdata1),
    .rsp_error(rsp_error1), .state_dbg(state_dbg1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic report_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  // ---------------- scoreboard monitors ----------------
  int   acc0 = 0, acc1 = 0;
  bit   in_rsp0 = 0, in_rsp1 = 0;
  exp_t cur0, cur1;

  always @(negedge clock) begin
    if (req_valid0 && req_ready0 && !reset0) acc0 = cyc + 1;
    if (rsp_valid0) begin
      if (!in_rsp0) begin
        if (exp_q0.size() == 0) report_fail("d0_unexpected_response");
        else begin
          cur0 = exp_q0.pop_front();
          in_rsp0 = 1;
          check("d0_latency", 32'(cyc - acc0 + 1), 32'(cur0.lat));
        end
      end
      if (in_rsp0) begin
        check("d0_rdata", rsp_rdata0, cur0.rdata);
        check("d0_error", 32'(rsp_error0), 32'(cur0.error));
      end
      if (rsp_ready0) in_rsp0 = 0;
    end else begin
      in_rsp0 = 0;
      check("d0_idle_rdata", rsp_rdata0, 32'h0);
      check("d0_idle_error", 32'(rsp_error0), 32'h0);
    end
  end

  always @(negedge clock) begin
    if (req_valid1 && req_ready1 && !reset1) acc1 = cyc + 1;
    if (rsp_valid1) begin
      if (!in_rsp1) begin
        if (exp_q1.size() == 0) report_fail("d1_unexpected_response");
        else begin
          cur1 = exp_q1.pop_front();
          in_rsp1 = 1;
          check("d1_latency", 32'(cyc - acc1 + 1), 32'(cur1.lat));
        end
      end
      if (in_rsp1) begin
        check("d1_rdata", rsp_rdata1, cur1.rdata);
        check("d1_error", 32'(rsp_error1), 32'(cur1.error));
      end
      if (rsp_ready1) in_rsp1 = 0;
    end else begin
      in_rsp1 = 0;
      check("d1_idle_rdata", rsp_rdata1, 32'h0);
      check("d1_idle_error", 32'(rsp_error1), 32'h0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input int d, input logic v, input logic w, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] be);
    if (d == 0) begin
      req_valid0 = v; req_write0 = w; req_addr0 = a; req_wdata0 = wd; req_be0 = be;
    end else begin
      req_valid1 = v; req_write1 = w; req_addr1 = a; req_wdata1 = wd; req_be1 = be;
    end
  endtask

  // Returns the cycle number of the accept edge that follows.
  task automatic wait_accept(input int d, output int acc_at);
    bit got = 0;
    acc_at = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if ((d == 0) ? req_ready0 : req_ready1) begin
        got = 1;
        acc_at = cyc + 1;
        break;
      end
    end
    if (!got) report_fail($sformatf("d%0d_accept_timeout", d));
  endtask

  task automatic wait_idle(input int d);
    bit got = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if ((d == 0) ? req_ready0 : req_ready1) begin
        got = 1;
        break;
      end
    end
    if (!got) report_fail($sformatf("d%0d_idle_timeout", d));
  endtask

  task automatic push_exp(input int d, input logic [31:0] er, input logic ee, input int lat);
    exp_t e;
    e.rdata = er;
    e.error = ee;
    e.lat   = 8'(lat);
    if (d == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
  endtask

  task automatic access(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] be, input logic [31:0] er, input logic ee, input int lat);
    int acc_at;
    push_exp(d, er, ee, lat);
    @(posedge clock); #1;
    drive(d, 1'b1, w, a, wd, be);
    wait_accept(d, acc_at);
    @(posedge clock); #1;
    drive(d, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    wait_idle(d);
  endtask

  // ---------------- stimulus ----------------
  int a_first, a_second, rise;
  bit seen;

  initial begin
    reset0 = 1'b1; reset1 = 1'b1;
    rsp_ready0 = 1'b1; rsp_ready1 = 1'b1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    #12;
    check("d0_reset_req_ready", 32'(req_ready0), 32'h1);
    check("d0_reset_rsp_valid", 32'(rsp_valid0), 32'h0);
    check("d0_reset_state", 32'(state_dbg0), 32'(ST_IDLE));
    check("d1_reset_req_ready", 32'(req_ready1), 32'h1);
    check("d1_reset_rsp_valid", 32'(rsp_valid1), 32'h0);
    @(posedge clock); #1;
    reset0 = 1'b0; reset1 = 1'b0;

    // Full write, read back, partial-lane write, read back.
    access(0, 1'b1, BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, 32'h0,         1'b0, 3);
    access(0, 1'b0, BASE + 32'h10, 32'h0,         4'hF, 32'hDEAD_BEEF, 1'b0, 3);
    access(0, 1'b1, BASE + 32'h10, 32'h0000_1200, 4'h2, 32'h0,         1'b0, 3);
    access(0, 1'b0, BASE + 32'h10, 32'h0,         4'hF, 32'hDEAD_12EF, 1'b0, 3);

    // Rejected accesses answer after one cycle and leave memory alone.
    access(0, 1'b0, BASE + 32'h2,   32'h0,         4'hF, 32'h0, 1'b1, 1);
    access(0, 1'b0, BASE + 32'h400, 32'h0,         4'hF, 32'h0, 1'b1, 1);
    access(0, 1'b0, 32'h07FF_FFFC,  32'h0,         4'hF, 32'h0, 1'b1, 1);
    access(0, 1'b1, BASE + 32'h12,  32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1, 1);
    access(0, 1'b1, BASE + 32'h400, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1, 1);
    // Write with no lanes enabled is a valid no-op.
    access(0, 1'b1, BASE + 32'h10,  32'hFFFF_FFFF, 4'h0, 32'h0,         1'b0, 3);
    access(0, 1'b0, BASE + 32'h10,  32'h0,         4'hF, 32'hDEAD_12EF, 1'b0, 3);
    // Last word in the window.
    access(0, 1'b1, BASE + 32'h3FC, 32'h5A5A_0FF0, 4'hF, 32'h0,         1'b0, 3);
    access(0, 1'b0, BASE + 32'h3FC, 32'h0,         4'hF, 32'h5A5A_0FF0, 1'b0, 3);
    access(0, 1'b0, BASE + 32'h0,   32'h0,         4'hF, 32'h0,         1'b0, 3);

    // Backpressure: response held 5 cycles while a second read waits.
    access(0, 1'b1, BASE, 32'h1234_5678, 4'hF, 32'h0, 1'b0, 3);
    push_exp(0, 32'h1234_5678, 1'b0, 3);
    push_exp(0, 32'h1234_5678, 1'b0, 3);
    rsp_ready0 = 1'b0;
    @(posedge clock); #1;
    drive(0, 1'b1, 1'b0, BASE, 32'h0, 4'hF);
    wait_accept(0, a_first);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (rsp_valid0) begin seen = 1; break; end
    end
    if (!seen) report_fail("d0_hold_rsp_timeout");
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("d0_hold_req_ready", 32'(req_ready0), 32'h0);
      check("d0_hold_rsp_valid", 32'(rsp_valid0), 32'h1);
    end
    @(posedge clock); #1;
    rsp_ready0 = 1'b1;
    rise = cyc;
    wait_accept(0, a_second);
    check("d0_hold_second_accept", 32'(a_second - rise), 32'h2);
    @(posedge clock); #1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    wait_idle(0);

    // Reset during WAIT aborts the write.
    access(0, 1'b1, BASE + 32'h20, 32'hAAAA_AAAA, 4'hF, 32'h0, 1'b0, 3);
    @(posedge clock); #1;
    drive(0, 1'b1, 1'b1, BASE + 32'h20, 32'h1111_1111, 4'hF);
    wait_accept(0, a_first);
    @(posedge clock); #1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    check("d0_pre_reset_state", 32'(state_dbg0), 32'(ST_WAIT));
    reset0 = 1'b1;
    #1;
    check("d0_abort_rsp_valid", 32'(rsp_valid0), 32'h0);
    check("d0_abort_req_ready", 32'(req_ready0), 32'h1);
    check("d0_abort_state", 32'(state_dbg0), 32'(ST_IDLE));
    @(posedge clock); #1;
    reset0 = 1'b0;
    access(0, 1'b0, BASE + 32'h20, 32'h0, 4'hF, 32'hAAAA_AAAA, 1'b0, 3);
    access(0, 1'b0, BASE + 32'h10, 32'h0, 4'hF, 32'hDEAD_12EF, 1'b0, 3);

    // Read-only, zero-wait instance.
    access(1, 1'b1, BASE, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1, 1);
    access(1, 1'b0, BASE, 32'h0,         4'hF, 32'h0, 1'b0, 1);
    push_exp(1, 32'h0, 1'b0, 1);
    push_exp(1, 32'h0, 1'b0, 1);
    @(posedge clock); #1;
    drive(1, 1'b1, 1'b0, BASE, 32'h0, 4'hF);
    wait_accept(1, a_first);
    @(posedge clock); #1;
    drive(1, 1'b1, 1'b0, BASE + 32'h3FC, 32'h0, 4'hF);
    wait_accept(1, a_second);
    check("d1_b2b_spacing", 32'(a_second - a_first), 32'h2);
    @(posedge clock); #1;
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    wait_idle(1);

    // Drain.
    for (int i = 0; i < 20; i++) begin
      if (exp_q0.size() == 0 && exp_q1.size() == 0) break;
      @(negedge clock);
    end
    check("d0_queue_empty", 32'(exp_q0.size()), 32'h0);
    check("d1_queue_empty", 32'(exp_q1.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule
